// File: rtl/prng_fill_scheduler_if.sv
// Requester, response and engine signals of the PRNG fill scheduler.
// The scheduler uses the slave side and the requesters/engine use the master side.
`timescale 1ns/1ps
interface prng_fill_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_seed;
  logic [DATA_W-1:0] req0_n;
  logic [ADDR_W-1:0] req0_addr;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_seed;
  logic [DATA_W-1:0] req1_n;
  logic [ADDR_W-1:0] req1_addr;
  logic              resp0_done;
  logic              resp1_done;
  logic              resp0_err;
  logic              resp1_err;
  logic              eng_start;
  logic [DATA_W-1:0] eng_seed;
  logic [DATA_W-1:0] eng_n;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_busy;
  logic              eng_done;
  logic              active;
  logic              grant_id;

  modport slave (
    input  req0_valid, req0_seed, req0_n, req0_addr,
    input  req1_valid, req1_seed, req1_n, req1_addr,
    input  eng_busy, eng_done,
    output req0_ready, req1_ready,
    output resp0_done, resp1_done, resp0_err, resp1_err,
    output eng_start, eng_seed, eng_n, eng_addr,
    output active, grant_id
  );

  modport master (
    output req0_valid, req0_seed, req0_n, req0_addr,
    output req1_valid, req1_seed, req1_n, req1_addr,
    output eng_busy, eng_done,
    input  req0_ready, req1_ready,
    input  resp0_done, resp1_done, resp0_err, resp1_err,
    input  eng_start, eng_seed, eng_n, eng_addr,
    input  active, grant_id
  );
endinterface

// File: rtl/prng_fill_scheduler.sv
// Round-robin scheduler that lets two requesters share one PRNG-to-BRAM fill engine,
// validating each job, launching the engine and returning a done/err pulse.
`timescale 1ns/1ps
module prng_fill_scheduler #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  prng_fill_scheduler_if.slave bus
);

  // state  | meaning
  // IDLE   | no job; pick a winner when any requester is valid
  // GRANT  | ready to the winner, payload captured
  // CHECK  | reject empty or out-of-range jobs
  // LAUNCH | one-cycle engine start pulse
  // WAIT   | wait for engine done rising edge or timeout
  // RESP   | one-cycle done/err pulse to the owner

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W:0]   DEPTH    = (DATA_W + 1)'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic              grant_q;
  logic              rr_q;
  logic              err_q, err_d;
  logic              done_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              any_valid;
  logic              winner;
  logic              done_rise;
  logic              over_end;
  logic [DATA_W:0]   end_addr;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign winner    = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
  assign done_rise = bus.eng_done & ~done_q;

  // One extra bit so a huge count cannot wrap back into range.
  assign end_addr  = (DATA_W + 1)'(addr_q) + {1'b0, n_q};
  assign over_end  = end_addr > DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (n_q == '0) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (over_end) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion edge in the last cycle still counts as done.
        if (done_rise) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      seed_q  <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= bus.eng_done;
      err_q  <= err_d;
      if (state_q == S_IDLE && any_valid) begin
        grant_q <= winner;
      end
      if (state_q == S_GRANT) begin
        rr_q   <= ~grant_q;
        seed_q <= grant_q ? bus.req1_seed : bus.req0_seed;
        n_q    <= grant_q ? bus.req1_n    : bus.req0_n;
        addr_q <= grant_q ? bus.req1_addr : bus.req0_addr;
      end
      if (state_q == S_LAUNCH) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready = (state_q == S_GRANT) & ~grant_q;
  assign bus.req1_ready = (state_q == S_GRANT) &  grant_q;
  assign bus.resp0_done = (state_q == S_RESP) & ~grant_q & ~err_q;
  assign bus.resp1_done = (state_q == S_RESP) &  grant_q & ~err_q;
  assign bus.resp0_err  = (state_q == S_RESP) & ~grant_q &  err_q;
  assign bus.resp1_err  = (state_q == S_RESP) &  grant_q &  err_q;
  assign bus.eng_start  = (state_q == S_LAUNCH);
  assign bus.eng_seed   = seed_q;
  assign bus.eng_n      = n_q;
  assign bus.eng_addr   = addr_q;
  assign bus.active     = (state_q != S_IDLE);
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_prng_fill_scheduler.sv
// Self-checking bench for prng_fill_scheduler: vector table, fairness, random jobs
// against a job-level model, timeout, stale engine done and mid-job reset.
`timescale 1ns/1ps
module tb_prng_fill_scheduler;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4096;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef struct packed {
    logic [31:0] seed;
    logic [31:0] n;
    logic [9:0]  addr;
  } job_t;

  typedef struct packed {
    int          id;
    logic [31:0] seed;
    logic [31:0] n;
    logic [9:0]  addr;
    int          exp_err;
    int          exp_launch;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int start_cnt = 0, ready_cnt = 0, resp_cnt = 0, st_cyc = 0;
  logic [31:0] st_seed = '0, st_n = '0;
  logic [9:0]  st_addr = '0;

  int   eng_mode = 0;
  int   eng_delay = 10;
  int   eng_cnt = 0;
  logic stale_lvl = 1'b0;

  job_t jq0[$];
  job_t jq1[$];
  int   rr_m = 0;

  prng_fill_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  prng_fill_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic resp_any();
    return bus.resp0_done | bus.resp0_err | bus.resp1_done | bus.resp1_err;
  endfunction

  function automatic int outs_nonzero();
    int c;
    c = int'(bus.req0_ready) + int'(bus.req1_ready) + int'(bus.resp0_done) + int'(bus.resp1_done)
      + int'(bus.resp0_err) + int'(bus.resp1_err) + int'(bus.eng_start) + int'(bus.active)
      + int'(bus.grant_id) + int'(bus.eng_seed != 0) + int'(bus.eng_n != 0) + int'(bus.eng_addr != 0);
    return c;
  endfunction

  // Job-level reference: empty jobs complete at once, jobs past the end of BRAM are
  // rejected, anything else runs and completes unless the engine never answers.
  function automatic int model_launch(job_t j);
    return (j.n != 0 && longint'(j.addr) + longint'(j.n) <= DEPTH) ? 1 : 0;
  endfunction

  function automatic int model_err(job_t j);
    if (j.n == 0) return 0;
    if (longint'(j.addr) + longint'(j.n) > DEPTH) return 1;
    return (eng_mode == 1) ? 1 : 0;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.seed = $urandom;
    j.addr = 10'($urandom_range(0, DEPTH - 1));
    case ($urandom_range(0, 3))
      0:       j.n = 32'd0;
      1:       j.n = $urandom_range(1, 16);
      2:       j.n = 32'(DEPTH - int'(j.addr) + int'($urandom_range(0, 1)));
      default: j.n = $urandom;
    endcase
    return j;
  endfunction

  // Engine model: mode 0 answers after eng_delay cycles, 1 never answers,
  // 2 holds eng_done at stale_lvl.
  initial begin
    bus.eng_done = 1'b0;
    bus.eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.eng_done = 1'b0;
        bus.eng_busy = 1'b0;
        eng_cnt = 0;
      end else if (eng_mode == 2) begin
        bus.eng_done = stale_lvl;
      end else if (bus.eng_start) begin
        bus.eng_done = 1'b0;
        if (eng_mode == 0) begin
          bus.eng_busy = 1'b1;
          eng_cnt = eng_delay;
        end
      end else if (bus.eng_busy && eng_mode == 0) begin
        if (eng_cnt <= 1) begin
          bus.eng_done = 1'b1;
          bus.eng_busy = 1'b0;
        end else begin
          eng_cnt--;
        end
      end else if (bus.eng_done) begin
        bus.eng_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.eng_start) begin
          start_cnt++;
          st_seed = bus.eng_seed;
          st_n    = bus.eng_n;
          st_addr = bus.eng_addr;
          st_cyc  = cyc;
        end
        if (bus.req0_ready || bus.req1_ready) ready_cnt++;
        if (resp_any()) resp_cnt++;
      end
    end
  end

  task automatic drive_reqs();
    bus.req0_valid = (jq0.size() > 0);
    bus.req1_valid = (jq1.size() > 0);
    if (jq0.size() > 0) begin
      bus.req0_seed = jq0[0].seed; bus.req0_n = jq0[0].n; bus.req0_addr = jq0[0].addr;
    end
    if (jq1.size() > 0) begin
      bus.req1_seed = jq1[0].seed; bus.req1_n = jq1[0].n; bus.req1_addr = jq1[0].addr;
    end
  endtask

  // One arbitration round; called just after a rising edge.
  task automatic round(output int o_id, output int o_err, output int o_launch,
                       output int o_lat, output int o_rcyc);
    job_t j;
    int w, s0, r0, v_cyc, k, exp_err, exp_launch;
    o_id = -1; o_err = -1; o_launch = 0; o_lat = -1; o_rcyc = -1;
    if (jq0.size() == 0 && jq1.size() == 0) return;
    drive_reqs();
    v_cyc = cyc;
    w = (jq0.size() > 0 && jq1.size() > 0) ? rr_m : ((jq0.size() > 0) ? 0 : 1);
    j = (w == 0) ? jq0[0] : jq1[0];
    exp_err = model_err(j);
    exp_launch = model_launch(j);
    s0 = start_cnt;
    r0 = ready_cnt;
    k = 0;
    @(negedge clk);
    while (!(bus.req0_ready || bus.req1_ready) && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", int'(bus.req0_ready || bus.req1_ready), 1);
    chk("grant_winner", bus.req1_ready ? 1 : 0, w);
    rr_m = 1 - w;
    @(posedge clk); #1;
    if (w == 0) begin bus.req0_valid = 1'b0; void'(jq0.pop_front()); end
    else        begin bus.req1_valid = 1'b0; void'(jq1.pop_front()); end
    k = 0;
    forever begin
      @(negedge clk);
      if (resp_any() || k > TIMEOUT + 100) break;
      k++;
    end
    chk("resp_seen", int'(resp_any()), 1);
    chk("resp_onehot", int'(bus.resp0_done) + int'(bus.resp0_err) + int'(bus.resp1_done) + int'(bus.resp1_err), 1);
    o_id  = (bus.resp1_done || bus.resp1_err) ? 1 : 0;
    o_err = (bus.resp0_err || bus.resp1_err) ? 1 : 0;
    chk("resp_id", o_id, w);
    chk("resp_kind", o_err, exp_err);
    o_launch = start_cnt - s0;
    chk("launch_cnt", o_launch, exp_launch);
    chk("ready_once", ready_cnt - r0, 1);
    if (o_launch == 1) begin
      chk("eng_seed", st_seed, j.seed);
      chk("eng_n", st_n, j.n);
      chk("eng_addr", st_addr, j.addr);
    end
    o_rcyc = cyc;
    o_lat = cyc - v_cyc;
    @(negedge clk);
    chk("idle_after_resp", bus.active, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jq0.delete();
    jq1.delete();
    rr_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    job_t jb;
    int id, er, ln, lat, rc, s0, r0, k, rise_cyc;

    vecs[0] = '{0, 32'd1,  32'd4,          10'h00F, 0, 1, -1};
    vecs[1] = '{1, 32'd5,  32'd0,          10'h000, 0, 0,  3};
    vecs[2] = '{0, 32'd7,  32'd4,          10'h3FE, 1, 0,  3};
    vecs[3] = '{0, 32'd9,  32'd4,          10'h3FC, 0, 1, -1};
    vecs[4] = '{1, 32'd2,  32'd1,          10'h3FF, 0, 1, -1};
    vecs[5] = '{1, 32'd3,  32'd1025,       10'h000, 1, 0,  3};
    vecs[6] = '{0, 32'd4,  32'hFFFF_FFFF,  10'h3FF, 1, 0,  3};
    vecs[7] = '{1, 32'd11, 32'd1024,       10'h000, 0, 1, -1};

    bus.req0_valid = 1'b0; bus.req0_seed = '0; bus.req0_n = '0; bus.req0_addr = '0;
    bus.req1_valid = 1'b0; bus.req1_seed = '0; bus.req1_n = '0; bus.req1_addr = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_nonzero(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", outs_nonzero(), 0);

    // Table of single jobs, including range boundaries.
    for (int i = 0; i < 8; i++) begin
      jb = '{vecs[i].seed, vecs[i].n, vecs[i].addr};
      if (vecs[i].id == 0) jq0.push_back(jb); else jq1.push_back(jb);
      round(id, er, ln, lat, rc);
      chk("vec_id", id, vecs[i].id);
      chk("vec_err", er, vecs[i].exp_err);
      chk("vec_launch", ln, vecs[i].exp_launch);
      if (vecs[i].exp_lat >= 0) chk("vec_lat", lat, vecs[i].exp_lat);
    end

    // Fairness: both requesters busy with three jobs each.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      jq0.push_back('{32'(100 + i), 32'(i + 2), 10'(16 * i)});
      jq1.push_back('{32'(200 + i), 32'(i + 3), 10'(512 + 16 * i)});
    end
    for (int i = 0; i < 6; i++) begin
      round(id, er, ln, lat, rc);
      chk("fair_order", id, i % 2);
      chk("fair_done", er, 0);
    end

    // Random jobs from both requesters.
    for (int i = 0; i < 14; i++) jq0.push_back(rand_job());
    for (int i = 0; i < 12; i++) jq1.push_back(rand_job());
    while (jq0.size() > 0 || jq1.size() > 0) begin
      eng_delay = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0 && jq0.size() < 3) jq0.push_back(rand_job());
      round(id, er, ln, lat, rc);
    end
    eng_delay = 10;

    // Silent engine times out, next job runs normally.
    eng_mode = 1;
    jq0.push_back('{32'h55, 32'd4, 10'h010});
    round(id, er, ln, lat, rc);
    chk("timeout_err", er, 1);
    chk("timeout_lat", rc - st_cyc, TIMEOUT + 1);
    eng_mode = 0;
    jq0.push_back('{32'h66, 32'd4, 10'h020});
    round(id, er, ln, lat, rc);
    chk("after_timeout_done", er, 0);

    // eng_done still high from a previous job must not complete the new one.
    stale_lvl = 1'b1;
    eng_mode = 2;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    jq0.push_back('{32'h77, 32'd2, 10'h005});
    s0 = start_cnt;
    rise_cyc = 0;
    fork
      round(id, er, ln, lat, rc);
      begin
        k = 0;
        while (start_cnt == s0 && k < 50) begin @(negedge clk); k++; end
        r0 = resp_cnt;
        repeat (20) @(negedge clk);
        chk("stale_no_early", resp_cnt - r0, 0);
        stale_lvl = 1'b0;
        repeat (3) @(negedge clk);
        stale_lvl = 1'b1;
        rise_cyc = cyc;
      end
    join
    chk("stale_done", er, 0);
    chk("stale_after_rise", int'(rc > rise_cyc), 1);
    stale_lvl = 1'b0;
    repeat (2) @(negedge clk);
    eng_mode = 0;

    // Asynchronous reset while waiting on the engine.
    eng_mode = 1;
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_seed = 32'h99; bus.req1_n = 32'd8; bus.req1_addr = 10'h040;
    k = 0;
    @(negedge clk);
    while (!bus.req1_ready && k < 10) begin @(negedge clk); k++; end
    chk("rst_seq_grant", bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    k = 0;
    while (!bus.eng_start && k < 10) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk("rst_seq_active", bus.active, 1);
    r0 = resp_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs_nonzero(), 0);
    jq0.delete();
    jq1.delete();
    rr_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    eng_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_no_resp", resp_cnt - r0, 0);
    chk("rst_idle", bus.active, 0);
    @(posedge clk); #1;
    jq0.push_back('{32'h11, 32'd3, 10'h100});
    jq1.push_back('{32'h22, 32'd3, 10'h200});
    round(id, er, ln, lat, rc);
    chk("rst_first_grant", id, 0);
    round(id, er, ln, lat, rc);
    chk("rst_second_grant", id, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prng_fill_scheduler.md
Name: prng_fill_scheduler

Overview:
- Two-requester round-robin scheduler in front of the single PRNG-to-BRAM fill engine.
- Each requester submits a fill job: seed, word count n, BRAM start address.
- The scheduler validates the job, launches the engine with a one-cycle start pulse, holds the job parameters stable, and waits for engine completion.
- It then returns a per-requester done or error pulse, so the BRAM port and PRNG are never driven by two jobs at once.

Parameters:
- ADDR_W, 10, BRAM address width; depth = 2**ADDR_W words.
- DATA_W, 32, seed and count width.
- TIMEOUT, 4096, maximum cycles in WAIT before the job is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  job 0 accepted this cycle.
- req0_seed  in  DATA_W  PRNG seed.
- req0_n  in  DATA_W  words to write.
- req0_addr  in  ADDR_W  BRAM start address.
- req1_valid, req1_ready, req1_seed, req1_n, req1_addr  in/out/in/in/in  same widths as requester 0.
- resp0_done, resp1_done  out  1  one-cycle pulse: job completed.
- resp0_err, resp1_err  out  1  one-cycle pulse: job rejected or timed out.
- eng_start  out  1  one-cycle engine launch pulse.
- eng_seed  out  DATA_W  job seed to engine.
- eng_n  out  DATA_W  job count to engine.
- eng_addr  out  ADDR_W  job start address to engine.
- eng_busy  in  1  engine running.
- eng_done  in  1  engine finished (level or pulse).
- active  out  1  job in flight (state other than IDLE).
- grant_id  out  1  requester owning the current or last job.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; every output 0; rr pointer=0 (requester 0 preferred); timeout counter=0; registered eng_done_q=0.
- Reset mid-job: job is dropped silently, no resp pulse, eng_start=0. The engine is reset by the same rst_n.
- States: IDLE, GRANT, CHECK, LAUNCH, WAIT, RESP.
- IDLE: if either reqX_valid=1 -> GRANT.
  - Winner: the only valid requester; if both are valid, the requester indicated by the rr pointer.
  - grant_id is registered on this transition.
- GRANT: reqX_ready=1 for the winner only, for exactly one cycle.
  - Seed, n and addr are captured into internal registers on this edge.
  - rr pointer := ~winner.
  - Requester must hold valid and payload stable until ready; ready without valid cannot occur. -> CHECK.
- CHECK, one cycle:
  - n==0 -> RESP with done, no launch.
  - addr+n > 2**ADDR_W, computed in DATA_W+1 bits with no wrap -> RESP with err, no launch.
  - Otherwise -> LAUNCH.
- LAUNCH: eng_start=1 for one cycle; eng_seed/eng_n/eng_addr driven from captured registers and held constant until RESP exits. Timeout counter cleared. -> WAIT.
- WAIT: completion = eng_done & ~eng_done_q (rising edge), so a stale level from the previous job is ignored.
  - On completion -> RESP with done.
  - Counter increments each cycle; at counter==TIMEOUT-1 without completion -> RESP with err.
  - If completion and timeout coincide, done wins.
- RESP: respX_done or respX_err (X=grant_id) pulses for one cycle; never both. -> IDLE.
- Best-case latency, valid to done pulse: 4 cycles + engine time; valid to reject: 3 cycles.
- A requester may re-assert valid immediately after its resp. A new request is never accepted while active=1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1; no requester waits more than one job.

Test Plan:
- Reset, then req0 seed=1 n=4 addr=0x00F; engine model raises done 10 cycles after start -> req0_ready one cycle, eng_start one pulse with eng_n=4 eng_addr=0x00F eng_seed=1, resp0_done exactly once, active low afterwards.
- req0 and req1 valid in the same cycle after reset, 3 jobs each back-to-back -> grant order 0,1,0,1,0,1; six done pulses, each on the matching requester.
- req1 n=0 -> resp1_done 3 cycles after valid, eng_start never asserted. req0 addr=0x3FE n=4 -> resp0_err, no eng_start. req0 addr=0x3FC n=4 (exact fit) -> launched.
- Engine model never asserts done -> resp0_err exactly TIMEOUT+1 cycles after eng_start; next request is served normally.
- eng_done left high from the previous job when the new job launches -> no early completion; done pulse only after done falls and rises again.
- rst_n pulsed low during WAIT (asynchronously, mid-cycle) -> all outputs 0 immediately, no resp pulse; after release, both valid -> requester 0 granted first.
